// File: rtl/johnson_phase_decoder_pkg.sv
// Shared FSM state type and width helper for the Johnson phase decoder.
package johnson_phase_decoder_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_FAULT   = 2'd2
   } jpd_state_e;

   // Phase index width for an n-bit Johnson counter (2n states).
   function automatic int phase_width(input int n);
      return (2 * n > 1) ? $clog2(2 * n) : 1;
   endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Counter sample input and decoded phase/status outputs of the Johnson phase decoder.
interface johnson_phase_decoder_if
   import johnson_phase_decoder_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 8,
   parameter int ERR_W = 4
);
   localparam int PW = phase_width(N);

   logic [N-1:0]     q_in;
   logic [PW-1:0]    phase;
   logic [2*N-1:0]   phase_onehot;
   logic             legal;
   logic             locked;
   logic             illegal;
   logic             step_err;
   logic             wrap;
   logic [CNT_W-1:0] cycle_cnt;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output q_in,
      input  phase, phase_onehot, legal, locked, illegal, step_err, wrap, cycle_cnt, err_cnt
   );

   modport slave (
      input  q_in,
      output phase, phase_onehot, legal, locked, illegal, step_err, wrap, cycle_cnt, err_cnt
   );

endinterface

// File: rtl/johnson_phase_decoder_lut.sv
// Combinational decode of a Johnson counter sample into legal flag, phase index and one-hot strobe.
module johnson_phase_decoder_lut
   import johnson_phase_decoder_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = phase_width(N),
   localparam int S  = 2 * N
) (
   input  logic [N-1:0]  q,
   output logic          legal,
   output logic [PW-1:0] phase,
   output logic [S-1:0]  phase_onehot
);

   // Code for phase p: p ones filling from the MSB for p <= N, then ones draining from the MSB.
   function automatic logic [N-1:0] johnson_code(input int p);
      logic [N-1:0] c;
      c = '0;
      for (int b = 0; b < N; b++)
         c[b] = (p <= N) ? (b >= N - p) : (b < S - p);
      return c;
   endfunction

   generate
      for (genvar gi = 0; gi < S; gi++) begin : g_code
         localparam logic [N-1:0] CODE = johnson_code(gi);
         assign phase_onehot[gi] = (q == CODE);
      end
   endgenerate

   assign legal = |phase_onehot;

   logic [PW-1:0] pop;

   always_comb begin
      pop = PW'($countones(q));
      if (q[N-1] || (q == '0))
         phase = pop;
      else
         phase = PW'(S) - pop;
   end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase monitor: samples q_in, decodes phase, tracks lock and flags errors.
// Optional saturating error counter is enabled by defining JPD_ERR_COUNT_EN.
module johnson_phase_decoder
   import johnson_phase_decoder_pkg::*;
#(
   parameter int N        = 4,
   parameter int LOCK_CNT = 2,
   parameter int CNT_W    = 8,
   parameter int ERR_W    = 4
) (
   input logic                    CLK1,
   input logic                    reset,
   johnson_phase_decoder_if.slave bus
);

   localparam int PW = phase_width(N);
   localparam int S  = 2 * N;
   localparam int LW = $clog2(LOCK_CNT + 1);

   logic [N-1:0]     q_reg;
   jpd_state_e       state_reg, state_next;
   logic [LW-1:0]    lock_cnt_reg, lock_cnt_next;
   logic [PW-1:0]    prev_reg, prev_next, expected;
   logic [PW-1:0]    phase_reg;
   logic [S-1:0]     onehot_reg;
   logic             legal_reg;
   logic             illegal_reg, illegal_next;
   logic             step_err_reg, step_err_next;
   logic             wrap_reg, wrap_next;
   logic [CNT_W-1:0] cycle_cnt_reg;

   logic             dec_legal;
   logic [PW-1:0]    dec_phase;
   logic [S-1:0]     dec_onehot;

   johnson_phase_decoder_lut #(.N(N)) u_lut (
      .q            (q_reg),
      .legal        (dec_legal),
      .phase        (dec_phase),
      .phase_onehot (dec_onehot)
   );

   assign expected = (prev_reg == PW'(S - 1)) ? '0 : prev_reg + PW'(1);

   always_comb begin
      state_next    = state_reg;
      lock_cnt_next = lock_cnt_reg;
      prev_next     = dec_legal ? dec_phase : prev_reg;
      illegal_next  = 1'b0;
      step_err_next = 1'b0;
      wrap_next     = 1'b0;
      case (state_reg)
         ST_ACQUIRE: begin
            if (!dec_legal) begin
               state_next    = ST_FAULT;
               illegal_next  = 1'b1;
               lock_cnt_next = '0;
            end else if (dec_phase == expected) begin
               if (lock_cnt_reg + LW'(1) >= LW'(LOCK_CNT)) begin
                  state_next    = ST_LOCKED;
                  lock_cnt_next = '0;
               end else begin
                  lock_cnt_next = lock_cnt_reg + LW'(1);
               end
            end else if (dec_phase != prev_reg) begin
               lock_cnt_next = '0;
            end
         end
         ST_LOCKED: begin
            // A repeat of the previous phase is a held counter, not an error.
            if (!dec_legal) begin
               state_next   = ST_FAULT;
               illegal_next = 1'b1;
            end else if (dec_phase == expected) begin
               wrap_next = (prev_reg == PW'(S - 1));
            end else if (dec_phase != prev_reg) begin
               step_err_next = 1'b1;
            end
         end
         ST_FAULT: begin
            if (!dec_legal) begin
               illegal_next = 1'b1;
            end else begin
               state_next    = ST_ACQUIRE;
               lock_cnt_next = '0;
            end
         end
         default: begin
            state_next    = ST_ACQUIRE;
            lock_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge CLK1 or posedge reset) begin
      if (reset) begin
         q_reg         <= '0;
         state_reg     <= ST_ACQUIRE;
         lock_cnt_reg  <= '0;
         prev_reg      <= '0;
         phase_reg     <= '0;
         onehot_reg    <= '0;
         legal_reg     <= 1'b0;
         illegal_reg   <= 1'b0;
         step_err_reg  <= 1'b0;
         wrap_reg      <= 1'b0;
         cycle_cnt_reg <= '0;
      end else begin
         q_reg         <= bus.q_in;
         state_reg     <= state_next;
         lock_cnt_reg  <= lock_cnt_next;
         prev_reg      <= prev_next;
         phase_reg     <= dec_phase;
         onehot_reg    <= dec_onehot;
         legal_reg     <= dec_legal;
         illegal_reg   <= illegal_next;
         step_err_reg  <= step_err_next;
         wrap_reg      <= wrap_next;
         if (wrap_next)
            cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      end
   end

`ifdef JPD_ERR_COUNT_EN
   logic [ERR_W-1:0] err_cnt_reg;

   always_ff @(posedge CLK1 or posedge reset) begin
      if (reset)
         err_cnt_reg <= '0;
      else if ((illegal_next || step_err_next) && (err_cnt_reg != '1))
         err_cnt_reg <= err_cnt_reg + ERR_W'(1);
   end

   assign bus.err_cnt = err_cnt_reg;
`else
   assign bus.err_cnt = {ERR_W{1'b0}};
`endif

   assign bus.phase        = phase_reg;
   assign bus.phase_onehot = onehot_reg;
   assign bus.legal        = legal_reg;
   assign bus.locked       = (state_reg == ST_LOCKED);
   assign bus.illegal      = illegal_reg;
   assign bus.step_err     = step_err_reg;
   assign bus.wrap         = wrap_reg;
   assign bus.cycle_cnt    = cycle_cnt_reg;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder: table-driven reference model plus randomized traffic.
module tb_johnson_phase_decoder;

   localparam int N        = 4;
   localparam int LOCK_CNT = 2;
   localparam int CNT_W    = 8;
   localparam int ERR_W    = 4;

   logic CLK1  = 1'b0;
   logic reset = 1'b0;

   always #5 CLK1 = ~CLK1;

   johnson_phase_decoder_if #(.N(N), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

   johnson_phase_decoder #(
      .N(N), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W), .ERR_W(ERR_W)
   ) dut (
      .CLK1  (CLK1),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] seq [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};

   // Reference model state
   bit          m_locked;
   bit          m_fault;
   int          m_prev;
   int          m_run;
   int          m_cycles;
   int          m_errs;
   logic [3:0]  pend;
   logic [27:0] e_vec;
   int          cidx;

   function automatic int code_index(input logic [3:0] q);
      for (int i = 0; i < 8; i++)
         if (seq[i] == q) return i;
      return -1;
   endfunction

   function logic [27:0] dut_vec();
      return {bus.phase, bus.phase_onehot, bus.legal, bus.locked, bus.illegal,
              bus.step_err, bus.wrap, bus.cycle_cnt, bus.err_cnt};
   endfunction

   task automatic model_reset();
      m_locked = 0; m_fault = 0; m_prev = 0; m_run = 0;
      m_cycles = 0; m_errs = 0; pend = 4'b0000;
      e_vec = '0;
   endtask

   // Outputs expected after decoding sample s.
   task automatic model_eval(input logic [3:0] s);
      int idx, nxt, pop;
      bit ill, serr, wr;
      logic [2:0] ph;
      logic [7:0] oh;
      idx = code_index(s);
      ill = 0; serr = 0; wr = 0;
      pop = $countones(s);
      ph = 3'((s[3] || s == 4'b0000) ? pop : 8 - pop);
      oh = (idx >= 0) ? (8'b1 << idx) : 8'b0;
      if (idx < 0) begin
         ill = 1; m_fault = 1; m_locked = 0; m_run = 0;
      end else begin
         nxt = (m_prev + 1) % 8;
         if (m_fault) begin
            m_fault = 0; m_run = 0;
         end else if (m_locked) begin
            if (idx == nxt) begin
               if (m_prev == 7) begin wr = 1; m_cycles++; end
            end else if (idx != m_prev) begin
               serr = 1;
            end
         end else begin
            if (idx == nxt) begin
               m_run++;
               if (m_run >= LOCK_CNT) begin m_locked = 1; m_run = 0; end
            end else if (idx != m_prev) begin
               m_run = 0;
            end
         end
         m_prev = idx;
      end
`ifdef JPD_ERR_COUNT_EN
      if ((ill || serr) && m_errs < 15) m_errs++;
`endif
      e_vec = {ph, oh, (idx >= 0), m_locked, ill, serr, wr, 8'(m_cycles), 4'(m_errs)};
   endtask

   task automatic step(input logic [3:0] q);
      bus.q_in = q;
      @(posedge CLK1);
      #1;
      model_eval(pend);
      pend = q;
      $display("t=%0t q_in=%b phase=%0d oh=%b legal=%b locked=%b ill=%b serr=%b wrap=%b cyc=%0d err=%0d",
               $time, q, bus.phase, bus.phase_onehot, bus.legal, bus.locked, bus.illegal,
               bus.step_err, bus.wrap, bus.cycle_cnt, bus.err_cnt);
   endtask

   function automatic logic [3:0] random_illegal();
      logic [3:0] c;
      c = 4'(($urandom_range(0, 15)));
      while (code_index(c) >= 0) c = 4'($urandom_range(0, 15));
      return c;
   endfunction

   task automatic test_reset();
      bus.q_in = 4'b0000;
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (dut_vec() !== 28'h0) begin
         n_bad++;
         $display("FAIL reset_state: got %h want %h", dut_vec(), 28'h0);
      end
      #20 reset = 1'b0;
      model_reset();
      cidx = 0;
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 26; i++) begin
         step(seq[cidx]);
         cidx = (cidx + 1) % 8;
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL free_run[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
      n_cmp++;
      if (bus.locked !== 1'b1) begin
         n_bad++;
         $display("FAIL free_run_locked: got %b want 1", bus.locked);
      end
   endtask

   task automatic test_stall();
      while (cidx != 0) begin
         step(seq[cidx]);
         cidx = (cidx + 1) % 8;
      end
      for (int i = 0; i < 10; i++) begin
         step(4'b0000);
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL stall[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
      n_cmp++;
      if ({bus.phase, bus.locked, bus.step_err, bus.illegal, bus.wrap} !== 7'b000_1000) begin
         n_bad++;
         $display("FAIL stall_flags: got %b want 0001000",
                  {bus.phase, bus.locked, bus.step_err, bus.illegal, bus.wrap});
      end
      cidx = 1;
   endtask

   task automatic test_illegal();
      logic [3:0] pat [5] = '{4'b1010, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
      for (int i = 0; i < 5; i++) begin
         step(pat[i]);
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL illegal[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
      step(4'b0111);
      n_cmp++;
      if ({bus.illegal, bus.locked, bus.phase_onehot} !== {1'b0, 1'b1, 8'b0001_0000}) begin
         n_bad++;
         $display("FAIL illegal_relock: got %b want 0100010000",
                  {bus.illegal, bus.locked, bus.phase_onehot});
      end
      cidx = 6;
   endtask

   task automatic test_skip();
      while (cidx != 3) begin
         step(seq[cidx]);
         cidx = (cidx + 1) % 8;
      end
      cidx = 4;
      for (int i = 0; i < 5; i++) begin
         step(seq[cidx]);
         cidx = (cidx + 1) % 8;
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL skip[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         step(seq[cidx]);
         cidx = (cidx + 1) % 8;
      end
      #3 reset = 1'b1;
      #1;
      n_cmp++;
      if (dut_vec() !== 28'h0) begin
         n_bad++;
         $display("FAIL async_reset: got %h want %h", dut_vec(), 28'h0);
      end
      #20 reset = 1'b0;
      model_reset();
      cidx = 0;
      for (int i = 0; i < 12; i++) begin
         step(seq[cidx]);
         cidx = (cidx + 1) % 8;
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL post_reset[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
   endtask

   task automatic test_random();
      int r;
      logic [3:0] q;
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70) begin
            q = seq[cidx]; cidx = (cidx + 1) % 8;
         end else if (r < 80) begin
            q = seq[(cidx + 7) % 8];
         end else if (r < 88) begin
            q = random_illegal();
         end else begin
            cidx = $urandom_range(0, 7);
            q = seq[cidx]; cidx = (cidx + 1) % 8;
         end
         step(q);
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
   endtask

   task automatic test_long_run();
      for (int i = 0; i < 2100; i++) begin
         step(seq[cidx]);
         cidx = (cidx + 1) % 8;
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL long_run[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
   endtask

   task automatic test_err_sat();
      logic [3:0] want;
      for (int i = 0; i < 20; i++) begin
         step(random_illegal());
         n_cmp++;
         if (dut_vec() !== e_vec) begin
            n_bad++;
            $display("FAIL err_sat[%0d]: got %h want %h", i, dut_vec(), e_vec);
         end
      end
      step(random_illegal());
`ifdef JPD_ERR_COUNT_EN
      want = 4'd15;
`else
      want = 4'd0;
`endif
      n_cmp++;
      if (bus.err_cnt !== want) begin
         n_bad++;
         $display("FAIL err_cnt_final: got %0d want %0d", bus.err_cnt, want);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_illegal();
      test_skip();
      test_async_reset();
      test_random();
      test_long_run();
      test_async_reset();
      test_err_sat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
